// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - instruction memory, redirect and decode-slot signals of the fetch queue
interface fetch_queue_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  deq_count;
    logic        slot0_valid;
    logic [31:0] slot0_instr;
    logic [31:0] slot0_pc;
    logic        slot1_valid;
    logic [31:0] slot1_instr;
    logic [31:0] slot1_pc;

    // environment side: instruction memory, branch unit and decode
    modport master (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output deq_count,
        input  slot0_valid,
        input  slot0_instr,
        input  slot0_pc,
        input  slot1_valid,
        input  slot1_instr,
        input  slot1_pc
    );

    // fetch queue side
    modport slave (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  deq_count,
        output slot0_valid,
        output slot0_instr,
        output slot0_pc,
        output slot1_valid,
        output slot1_instr,
        output slot1_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC register plus small FIFO feeding a dual-issue decode stage
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   pc_q;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_p1;
    logic [CW-1:0] count;
    logic [CW-1:0] deq_req;
    logic [CW-1:0] eff_deq;
    logic [CW-1:0] count_next;
    logic          fetch;

    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc    [DEPTH];

    // Dequeue is clamped to what is actually queued; the illegal request 3 is
    // treated as 2 because decode only ever sees two slots. Fetch uses the
    // pre-dequeue occupancy, so a slot freed this cycle is refilled next cycle.
    always_comb begin
        deq_req    = (bus.deq_count == 2'd3) ? CW'(2) : CW'(bus.deq_count);
        eff_deq    = (deq_req > count) ? count : deq_req;
        fetch      = (count < DEPTH_C);
        count_next = count + CW'(fetch) - eff_deq;
    end

    // Control state: reset beats redirect, redirect beats fetch and dequeue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q   <= {RESET_PC[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            pc_q   <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                pc_q   <= pc_q + 32'd4;
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr + eff_deq[PW-1:0];
            count  <= count_next;
        end
    end

    // Entry storage: written only on a real fetch, contents need no reset.
    always_ff @(posedge clk) begin
        if (rst_n && !bus.redirect_valid && fetch) begin
            q_instr[wr_ptr] <= bus.imem_rdata;
            q_pc[wr_ptr]    <= pc_q;
        end
    end

    assign rd_ptr_p1       = rd_ptr + PW'(1);
    assign bus.imem_addr   = pc_q;
    assign bus.slot0_valid = (count >= CW'(1));
    assign bus.slot0_instr = q_instr[rd_ptr];
    assign bus.slot0_pc    = q_pc[rd_ptr];
    assign bus.slot1_valid = (count >= CW'(2));
    assign bus.slot1_instr = q_instr[rd_ptr_p1];
    assign bus.slot1_pc    = q_pc[rd_ptr_p1];
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue model
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk;
    logic rst_n;
    fetch_queue_if bus();

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    logic [31:0] mpc;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hFFC4_A303;
            32'h4:   return 32'h0064_A423;
            32'h8:   return 32'h0062_E233;
            32'hC:   return 32'hFE42_0AE3;
            default: return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
        endcase
    endfunction

    always_comb bus.imem_rdata = mem_word(bus.imem_addr);

    // Drive one cycle of inputs, clock it, advance the model, return at negedge.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input int dq);
        int n;
        bit do_fetch;
        rst_n              = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.deq_count      = 2'(dq);
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            mpc = 32'h0;
        end else if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            do_fetch = (mq.size() < DEPTH);
            n = (dq < mq.size()) ? dq : mq.size();
            for (int i = 0; i < n; i++) void'(mq.pop_front());
            if (do_fetch) begin
                mq.push_back('{pc: mpc, instr: mem_word(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0);
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, 32'h0); end
        checks++; if (bus.slot0_valid !== 1'b0) begin errors++; $display("FAIL reset_v0 got %b want 0", bus.slot0_valid); end
        checks++; if (bus.slot1_valid !== 1'b0) begin errors++; $display("FAIL reset_v1 got %b want 0", bus.slot1_valid); end
        step(1, 0, 32'h0, 0);
        checks++; if (bus.slot0_valid !== 1'b1) begin errors++; $display("FAIL first_v0 got %b want 1", bus.slot0_valid); end
        checks++; if (bus.slot0_instr !== 32'hFFC4_A303) begin errors++; $display("FAIL first_instr got %h want FFC4A303", bus.slot0_instr); end
        checks++; if (bus.slot0_pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", bus.slot0_pc); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0);
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL fill_addr got %h want 10", bus.imem_addr); end
        step(1, 0, 32'h0, 0);
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL full_hold_addr got %h want 10", bus.imem_addr); end
        checks++; if (bus.slot0_instr !== 32'hFFC4_A303 || bus.slot0_pc !== 32'h0)
            begin errors++; $display("FAIL fill_slot0 got %h@%h want FFC4A303@0", bus.slot0_instr, bus.slot0_pc); end
        checks++; if (bus.slot1_valid !== 1'b1 || bus.slot1_instr !== 32'h0064_A423 || bus.slot1_pc !== 32'h4)
            begin errors++; $display("FAIL fill_slot1 got %b %h@%h want 1 0064A423@4", bus.slot1_valid, bus.slot1_instr, bus.slot1_pc); end
    endtask

    task automatic test_dual_dequeue;
        step(1, 0, 32'h0, 2);
        checks++; if (bus.slot0_instr !== 32'h0062_E233 || bus.slot0_pc !== 32'h8)
            begin errors++; $display("FAIL deq2_slot0 got %h@%h want 0062E233@8", bus.slot0_instr, bus.slot0_pc); end
        checks++; if (bus.slot1_valid !== 1'b1 || bus.slot1_instr !== 32'hFE42_0AE3 || bus.slot1_pc !== 32'hC)
            begin errors++; $display("FAIL deq2_slot1 got %b %h@%h want 1 FE420AE3@C", bus.slot1_valid, bus.slot1_instr, bus.slot1_pc); end
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL deq2_blocked_addr got %h want 10", bus.imem_addr); end
        step(1, 0, 32'h0, 0);
        checks++; if (bus.imem_addr !== 32'h14) begin errors++; $display("FAIL resume_addr got %h want 14", bus.imem_addr); end
        checks++; if (bus.slot0_pc !== 32'h8) begin errors++; $display("FAIL resume_slot0 got %h want 8", bus.slot0_pc); end
    endtask

    task automatic test_redirect;
        step(1, 1, 32'h0000_0007, 2);
        checks++; if (bus.slot0_valid !== 1'b0 || bus.slot1_valid !== 1'b0)
            begin errors++; $display("FAIL redir_flush got %b%b want 00", bus.slot0_valid, bus.slot1_valid); end
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL redir_addr got %h want 4", bus.imem_addr); end
        step(1, 0, 32'h0, 0);
        checks++; if (bus.slot0_valid !== 1'b1 || bus.slot0_instr !== 32'h0064_A423 || bus.slot0_pc !== 32'h4)
            begin errors++; $display("FAIL redir_slot0 got %b %h@%h want 1 0064A423@4", bus.slot0_valid, bus.slot0_instr, bus.slot0_pc); end
    endtask

    task automatic test_clamp;
        step(1, 0, 32'h0, 2);
        checks++; if (bus.slot0_valid !== 1'b1 || bus.slot0_pc !== 32'h8)
            begin errors++; $display("FAIL clamp_slot0 got %b @%h want 1 @8", bus.slot0_valid, bus.slot0_pc); end
        checks++; if (bus.slot1_valid !== 1'b0) begin errors++; $display("FAIL clamp_v1 got %b want 0", bus.slot1_valid); end
        checks++; if (bus.imem_addr !== 32'hC) begin errors++; $display("FAIL clamp_addr got %h want C", bus.imem_addr); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0)
                step(1, 1, $urandom, $urandom_range(0, 2));
            else
                step(1, 0, $urandom, $urandom_range(0, 2));
            checks++; if (bus.imem_addr !== mpc) begin errors++; $display("FAIL rnd_addr c=%0d got %h want %h", c, bus.imem_addr, mpc); end
            checks++; if (bus.slot0_valid !== (mq.size() >= 1)) begin errors++; $display("FAIL rnd_v0 c=%0d got %b want %b", c, bus.slot0_valid, mq.size() >= 1); end
            checks++; if (bus.slot1_valid !== (mq.size() >= 2)) begin errors++; $display("FAIL rnd_v1 c=%0d got %b want %b", c, bus.slot1_valid, mq.size() >= 2); end
            if (mq.size() >= 1) begin
                checks++; if (bus.slot0_pc !== mq[0].pc || bus.slot0_instr !== mq[0].instr)
                    begin errors++; $display("FAIL rnd_slot0 c=%0d got %h@%h want %h@%h", c, bus.slot0_instr, bus.slot0_pc, mq[0].instr, mq[0].pc); end
            end
            if (mq.size() >= 2) begin
                checks++; if (bus.slot1_pc !== mq[1].pc || bus.slot1_instr !== mq[1].instr)
                    begin errors++; $display("FAIL rnd_slot1 c=%0d got %h@%h want %h@%h", c, bus.slot1_instr, bus.slot1_pc, mq[1].instr, mq[1].pc); end
            end
        end
    endtask

    task automatic test_pc_wrap;
        step(1, 1, 32'hFFFF_FFF8, 0);
        checks++; if (bus.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_redir_addr got %h want FFFFFFF8", bus.imem_addr); end
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0);
        checks++; if (bus.slot0_pc !== 32'hFFFF_FFF8 || bus.slot1_pc !== 32'hFFFF_FFFC)
            begin errors++; $display("FAIL wrap_pcs got %h,%h want FFFFFFF8,FFFFFFFC", bus.slot0_pc, bus.slot1_pc); end
        checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_addr got %h want 4", bus.imem_addr); end
        step(1, 0, 32'h0, 2);
        checks++; if (bus.slot0_pc !== 32'h0 || bus.slot0_instr !== 32'hFFC4_A303)
            begin errors++; $display("FAIL wrap_slot0 got %h@%h want FFC4A303@0", bus.slot0_instr, bus.slot0_pc); end
        step(0, 0, 32'h0, 0);
        checks++; if (bus.slot0_valid !== 1'b0 || bus.slot1_valid !== 1'b0 || bus.imem_addr !== 32'h0)
            begin errors++; $display("FAIL midfill_reset got %b%b %h want 00 0", bus.slot0_valid, bus.slot1_valid, bus.imem_addr); end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.deq_count      = 2'd0;
        mpc                = 32'h0;
        @(negedge clk);
        test_reset;
        test_fill;
        test_dual_dequeue;
        test_redirect;
        test_clamp;
        test_random;
        test_pc_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
